// File: rtl/dram_pkg.sv
// Shared constants and FSM encoding for the data-RAM responder.
package dram_pkg;

    localparam int unsigned DRAM_LANES = 4;

    localparam logic [DRAM_LANES-1:0] DRAM_BE_NONE = 4'b0000;
    localparam logic [DRAM_LANES-1:0] DRAM_BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RD,
        S_RESP
    } dram_state_e;

endpackage

// File: rtl/dram_bank.sv
// Byte-lane SRAM bank: one 8-bit array per lane, per-lane write enable, registered read port.
module dram_bank
    import dram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [DRAM_LANES-1:0]          we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [31:0]                    wdat_i,
    input  logic                           rd_en_i,
    input  logic                           rd_zero_i,
    output logic [31:0]                    rdata_o
);

    for (genvar i = 0; i < DRAM_LANES; i++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd_q;

        always_ff @(posedge clk_i) begin
            if (we_i[i]) begin
                mem[addr_i] <= wdat_i[8*i +: 8];
            end
        end

        // Only the read register is reset; array contents survive reset.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rd_q <= '0;
            end else if (rd_en_i) begin
                rd_q <= rd_zero_i ? 8'h00 : mem[addr_i];
            end
        end

        assign rdata_o[8*i +: 8] = rd_q;
    end

endmodule

// File: rtl/dram_resp.sv
// Data-RAM responder: ready/valid front end, wait-state FSM and range check around dram_bank.
module dram_resp
    import dram_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT        = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dram_req,
    input  logic [3:0]        dram_we_byte,
    input  logic [ADDR_W-1:0] dram_addr,
    input  logic [31:0]       dram_wdat,
    output logic              dram_ready,
    output logic [31:0]       dram_dout,
    output logic              dram_rvalid,
    output logic              dram_err
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam bit          WAIT0    = (WAIT == 0);
    localparam logic [1:0]  CNT_INIT = WAIT0 ? 2'd0 : 2'(WAIT - 1);

    dram_state_e      state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic             oor_q;
    logic             rvalid_q, rvalid_d;
    logic             err_q, err_d;

    logic [ADDR_W-3:0]     word_idx;
    logic                  oor;
    logic                  accept;
    logic                  is_read;
    logic                  rd_en;
    logic                  rd_zero;
    logic [IDX_W-1:0]      bank_addr;
    logic [DRAM_LANES-1:0] bank_we;
    logic                  unused_addr;

    assign word_idx    = dram_addr[ADDR_W-1:2];
    assign unused_addr = ^dram_addr[1:0];

    // Any set bit above the array index means out of range; no truncation into range.
    if (ADDR_W - 2 > IDX_W) begin : g_range
        assign oor = |word_idx[ADDR_W-3:IDX_W];
    end else begin : g_full
        assign oor = 1'b0;
    end

    assign dram_ready = (state_q != S_WAIT_RD);
    assign accept     = dram_req & dram_ready & ~rst;
    assign is_read    = (dram_we_byte == DRAM_BE_NONE);

    assign bank_we   = (accept && !oor) ? dram_we_byte : DRAM_BE_NONE;
    assign bank_addr = (state_q == S_WAIT_RD) ? idx_q : word_idx[IDX_W-1:0];

    // With wait states the array is read on the last wait edge so dout only moves with rvalid.
    assign rd_en   = WAIT0 ? (accept & is_read) : (state_q == S_WAIT_RD && cnt_q == 2'd0);
    assign rd_zero = WAIT0 ? oor : oor_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (accept && is_read && !WAIT0) begin
                    state_d = S_WAIT_RD;
                    cnt_d   = CNT_INIT;
                end
            end
            S_WAIT_RD: begin
                if (cnt_q == 2'd0) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    err_d    = oor_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept && (!is_read || WAIT0)) begin
            rvalid_d = is_read;
            err_d    = oor;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            idx_q    <= '0;
            oor_q    <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            if (accept) begin
                idx_q <= word_idx[IDX_W-1:0];
                oor_q <= oor;
            end
        end
    end

    dram_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk_i    (clk),
        .rst_i    (rst),
        .we_i     (bank_we),
        .addr_i   (bank_addr),
        .wdat_i   (dram_wdat),
        .rd_en_i  (rd_en),
        .rd_zero_i(rd_zero),
        .rdata_o  (dram_dout)
    );

    assign dram_rvalid = rvalid_q;
    assign dram_err    = err_q;

endmodule

// File: tb/tb_dram_resp.sv
// Bench for dram_resp: three instances (WAIT=0,2,3) checked against an associative-array memory model.
module tb_dram_resp;
    import dram_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [2:0]  ready, rvalid, err;
    logic [3:0]  we_byte = 4'b0000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic [31:0] dout [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl [int unsigned];

    always #5 clk = ~clk;

    dram_resp #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst), .dram_req(req[0]), .dram_we_byte(we_byte), .dram_addr(addr),
        .dram_wdat(wdat), .dram_ready(ready[0]), .dram_dout(dout[0]), .dram_rvalid(rvalid[0]),
        .dram_err(err[0]));
    dram_resp #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .WAIT(2)) u_w2 (
        .clk(clk), .rst(rst), .dram_req(req[1]), .dram_we_byte(we_byte), .dram_addr(addr),
        .dram_wdat(wdat), .dram_ready(ready[1]), .dram_dout(dout[1]), .dram_rvalid(rvalid[1]),
        .dram_err(err[1]));
    dram_resp #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .WAIT(3)) u_w3 (
        .clk(clk), .rst(rst), .dram_req(req[2]), .dram_we_byte(we_byte), .dram_addr(addr),
        .dram_wdat(wdat), .dram_ready(ready[2]), .dram_dout(dout[2]), .dram_rvalid(rvalid[2]),
        .dram_err(err[2]));

    function automatic int wait_of(int s);
        return (s == 0) ? 0 : ((s == 1) ? 2 : 3);
    endfunction

    function automatic bit in_range(logic [31:0] a);
        return (a >> 2) < DEPTH;
    endfunction

    function automatic int unsigned key(int s, logic [31:0] a);
        return {s[1:0], a[31:2]};
    endfunction

    function automatic void mdl_write(int s, logic [3:0] be, logic [31:0] a, logic [31:0] d);
        logic [31:0] w;
        if (!in_range(a)) return;
        w = mdl.exists(key(s, a)) ? mdl[key(s, a)] : 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
        mdl[key(s, a)] = w;
    endfunction

    function automatic logic [31:0] mdl_read(int s, logic [31:0] a);
        if (!in_range(a) || !mdl.exists(key(s, a))) return 32'h0;
        return mdl[key(s, a)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request to instance s, wait for ready, and leave just after the acceptance edge.
    task automatic send(int s, logic [3:0] be, logic [31:0] a, logic [31:0] d);
        int budget = 20;
        req[s] = 1'b1; we_byte = be; addr = a; wdat = d;
        while (ready[s] !== 1'b1 && budget > 0) begin tick(); budget--; end
        if (ready[s] !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL send_ready dut%0d: ready=%b required 1", s, ready[s]);
        end
        tick();
        req[s] = 1'b0;
        if (be != DRAM_BE_NONE) mdl_write(s, be, a, d);
    endtask

    task automatic await_rvalid(input int s, output int lat);
        lat = 1;
        while (rvalid[s] !== 1'b1 && lat < 10) begin tick(); lat++; end
        if (rvalid[s] !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            n_checks++; if (ready[s] !== 1'b1) begin n_fail++; $display("FAIL reset_ready dut%0d: got %b want 1", s, ready[s]); end
            n_checks++; if (rvalid[s] !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid dut%0d: got %b want 0", s, rvalid[s]); end
            n_checks++; if (err[s] !== 1'b0) begin n_fail++; $display("FAIL reset_err dut%0d: got %b want 0", s, err[s]); end
            n_checks++; if (dout[s] !== 32'h0) begin n_fail++; $display("FAIL reset_dout dut%0d: got %h want 0", s, dout[s]); end
        end
    endtask

    task automatic init_mem();
        for (int s = 0; s < 3; s++)
            for (int w = 0; w < 16; w++) send(s, DRAM_BE_WORD, 32'(w * 4), $urandom);
        tick();
    endtask

    task automatic test_wait0();
        send(0, DRAM_BE_WORD, 32'h10, 32'hDEADBEEF);
        n_checks++; if (rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL wait0_wr_rvalid: got %b want 0", rvalid[0]); end
        n_checks++; if (ready[0] !== 1'b1) begin n_fail++; $display("FAIL wait0_wr_ready: got %b want 1", ready[0]); end
        send(0, DRAM_BE_NONE, 32'h10, 32'h0);
        n_checks++; if (rvalid[0] !== 1'b1) begin n_fail++; $display("FAIL wait0_rd_rvalid: got %b want 1", rvalid[0]); end
        n_checks++; if (dout[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wait0_rd_dout: got %h want deadbeef", dout[0]); end
        n_checks++; if (ready[0] !== 1'b1) begin n_fail++; $display("FAIL wait0_rd_ready: got %b want 1", ready[0]); end
        tick();
        n_checks++; if (rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL wait0_rvalid_pulse: got %b want 0", rvalid[0]); end
    endtask

    task automatic test_byte_lanes();
        send(0, 4'b0100, 32'h10, 32'h00AA0000);
        n_checks++; if (rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL lanes_wr_rvalid: got %b want 0", rvalid[0]); end
        send(0, DRAM_BE_NONE, 32'h13, 32'h0);
        n_checks++; if (rvalid[0] !== 1'b1) begin n_fail++; $display("FAIL lanes_rvalid: got %b want 1", rvalid[0]); end
        n_checks++; if (dout[0] !== 32'hDEAABEEF) begin n_fail++; $display("FAIL lanes_dout: got %h want deaabeef", dout[0]); end
        for (int s = 1; s < 3; s++) begin
            send(s, DRAM_BE_WORD, 32'h10, 32'hDEADBEEF);
            send(s, 4'b0100, 32'h10, 32'h00AA0000);
        end
        tick();
    endtask

    task automatic test_wait_stall();
        send(1, DRAM_BE_NONE, 32'h10, 32'h0);
        n_checks++; if (ready[1] !== 1'b0) begin n_fail++; $display("FAIL stall_ready_t1: got %b want 0", ready[1]); end
        n_checks++; if (rvalid[1] !== 1'b0) begin n_fail++; $display("FAIL stall_rvalid_t1: got %b want 0", rvalid[1]); end
        req[1] = 1'b1; we_byte = DRAM_BE_NONE; addr = 32'h14;
        tick();
        n_checks++; if (ready[1] !== 1'b0) begin n_fail++; $display("FAIL stall_ready_t2: got %b want 0", ready[1]); end
        n_checks++; if (rvalid[1] !== 1'b0) begin n_fail++; $display("FAIL stall_rvalid_t2: got %b want 0", rvalid[1]); end
        tick();
        n_checks++; if (ready[1] !== 1'b1) begin n_fail++; $display("FAIL stall_ready_t3: got %b want 1", ready[1]); end
        n_checks++; if (rvalid[1] !== 1'b1) begin n_fail++; $display("FAIL stall_rvalid_t3: got %b want 1", rvalid[1]); end
        n_checks++; if (dout[1] !== 32'hDEAABEEF) begin n_fail++; $display("FAIL stall_dout_t3: got %h want deaabeef", dout[1]); end
        tick();
        req[1] = 1'b0;
        n_checks++; if (ready[1] !== 1'b0) begin n_fail++; $display("FAIL held_ready_t4: got %b want 0", ready[1]); end
        n_checks++; if (rvalid[1] !== 1'b0) begin n_fail++; $display("FAIL held_rvalid_t4: got %b want 0", rvalid[1]); end
        tick();
        n_checks++; if (dout[1] !== 32'hDEAABEEF) begin n_fail++; $display("FAIL held_dout_hold: got %h want deaabeef", dout[1]); end
        tick();
        n_checks++; if (rvalid[1] !== 1'b1) begin n_fail++; $display("FAIL held_rvalid_t6: got %b want 1", rvalid[1]); end
        n_checks++; if (dout[1] !== mdl_read(1, 32'h14)) begin n_fail++; $display("FAIL held_dout_t6: got %h want %h", dout[1], mdl_read(1, 32'h14)); end
        tick();
    endtask

    task automatic test_out_of_range();
        int lat;
        for (int s = 0; s < 3; s++) begin
            send(s, DRAM_BE_WORD, 32'h4000, 32'h12345678);
            n_checks++; if (err[s] !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err dut%0d: got %b want 1", s, err[s]); end
            n_checks++; if (rvalid[s] !== 1'b0) begin n_fail++; $display("FAIL oor_wr_rvalid dut%0d: got %b want 0", s, rvalid[s]); end
            tick();
            n_checks++; if (err[s] !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse dut%0d: got %b want 0", s, err[s]); end
            send(s, DRAM_BE_NONE, 32'h0, 32'h0);
            await_rvalid(s, lat);
            n_checks++; if (dout[s] !== mdl_read(s, 32'h0)) begin n_fail++; $display("FAIL oor_mem_kept dut%0d: got %h want %h", s, dout[s], mdl_read(s, 32'h0)); end
            tick();
            send(s, DRAM_BE_NONE, 32'h4000, 32'h0);
            await_rvalid(s, lat);
            n_checks++; if (lat != 1 + wait_of(s)) begin n_fail++; $display("FAIL oor_rd_latency dut%0d: got %0d want %0d", s, lat, 1 + wait_of(s)); end
            n_checks++; if (err[s] !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err dut%0d: got %b want 1", s, err[s]); end
            n_checks++; if (dout[s] !== 32'h0) begin n_fail++; $display("FAIL oor_rd_dout dut%0d: got %h want 0", s, dout[s]); end
            tick();
        end
    endtask

    task automatic test_reset_mid_read();
        int lat;
        int seen = 0;
        send(2, DRAM_BE_NONE, 32'h10, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (ready[2] !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", ready[2]); end
        n_checks++; if (dout[2] !== 32'h0) begin n_fail++; $display("FAIL rstmid_dout: got %h want 0", dout[2]); end
        for (int i = 0; i < 5; i++) begin
            if (rvalid[2] === 1'b1 || err[2] === 1'b1) seen++;
            tick();
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_no_resp: got %0d pulses want 0", seen); end
        send(2, DRAM_BE_NONE, 32'h10, 32'h0);
        await_rvalid(2, lat);
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 4", lat); end
        n_checks++; if (dout[2] !== 32'hDEAABEEF) begin n_fail++; $display("FAIL rstmid_mem_kept: got %h want deaabeef", dout[2]); end
        tick();
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 8; k++) send(0, DRAM_BE_WORD, 32'(k * 4), $urandom);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (ready[0] !== 1'b1) begin n_fail++; $display("FAIL stream_ready%0d: got %b want 1", k, ready[0]); end
            req[0] = 1'b1; we_byte = DRAM_BE_NONE; addr = 32'(k * 4);
            tick();
            n_checks++; if (rvalid[0] !== 1'b1) begin n_fail++; $display("FAIL stream_rvalid%0d: got %b want 1", k, rvalid[0]); end
            n_checks++; if (dout[0] !== mdl_read(0, 32'(k * 4))) begin n_fail++; $display("FAIL stream_dout%0d: got %h want %h", k, dout[0], mdl_read(0, 32'(k * 4))); end
        end
        req[0] = 1'b0;
        tick();
        n_checks++; if (rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL stream_end_rvalid: got %b want 0", rvalid[0]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            int          s   = int'($urandom_range(0, 2));
            logic [3:0]  be  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            logic [31:0] a   = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h4000)
                                                           : 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            logic [31:0] d   = $urandom;
            logic [31:0] exp = mdl_read(s, a);
            bit          inr = in_range(a);
            int          lat;
            send(s, be, a, d);
            if (be != DRAM_BE_NONE) begin
                n_checks++; if (err[s] !== !inr) begin n_fail++; $display("FAIL rnd_wr_err dut%0d a=%h: got %b want %b", s, a, err[s], !inr); end
                n_checks++; if (rvalid[s] !== 1'b0) begin n_fail++; $display("FAIL rnd_wr_rvalid dut%0d: got %b want 0", s, rvalid[s]); end
            end else begin
                await_rvalid(s, lat);
                n_checks++; if (lat != 1 + wait_of(s)) begin n_fail++; $display("FAIL rnd_rd_latency dut%0d: got %0d want %0d", s, lat, 1 + wait_of(s)); end
                n_checks++; if (dout[s] !== exp) begin n_fail++; $display("FAIL rnd_rd_dout dut%0d a=%h: got %h want %h", s, a, dout[s], exp); end
                n_checks++; if (err[s] !== !inr) begin n_fail++; $display("FAIL rnd_rd_err dut%0d a=%h: got %b want %b", s, a, err[s], !inr); end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        init_mem();
        test_wait0();
        test_byte_lanes();
        test_wait_stall();
        test_out_of_range();
        test_reset_mid_read();
        test_streaming();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
